wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the main pipeline and a multi-cycle unit.
// Pipeline wins by default; a starved multi-cycle result eventually forces a pipeline stall.
module wb_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned STARVE_LIMIT  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        pipe_valid,
   input  logic [ADDRESS_WIDTH-1:0]    pipe_addr,
   input  logic [DATA_WIDTH-1:0]       pipe_data,
   input  logic                        mc_issue,
   input  logic [ADDRESS_WIDTH-1:0]    mc_issue_addr,
   input  logic                        mc_valid,
   input  logic [ADDRESS_WIDTH-1:0]    mc_addr,
   input  logic [DATA_WIDTH-1:0]       mc_data,
   output logic                        mc_ready,
   output logic                        stall_req,
   output logic                        rf_write_en,
   output logic [ADDRESS_WIDTH-1:0]    rf_write_addr,
   output logic [DATA_WIDTH-1:0]       rf_write_data,
   output logic [2**ADDRESS_WIDTH-1:0] busy_mask
);

   localparam int unsigned NumRegs  = 2**ADDRESS_WIDTH;
   localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntWidth-1:0] CntLimit = CntWidth'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StForce
   } state_e;

   state_e              r_state;
   logic [CntWidth-1:0] r_wait_cnt;
   logic                r_stall;
   logic [NumRegs-1:0]  r_busy;

   logic                w_force;
   logic                w_mc_ready;
   logic                w_xfer;
   logic                w_pipe_grant;
   logic                w_refused;
   logic [CntWidth-1:0] w_cnt_inc;
   logic                w_starved;
   logic [NumRegs-1:0]  w_busy_nxt;

   assign w_force      = (r_state == StForce);
   assign w_mc_ready   = w_force | ~pipe_valid;
   assign w_xfer       = mc_valid & w_mc_ready;
   assign w_pipe_grant = pipe_valid & ~w_force;
   assign w_refused    = mc_valid & ~w_mc_ready;

   // The refusal that moves IDLE->WAIT is counted too, so a limit of 1 forces on the next cycle.
   assign w_cnt_inc = (r_wait_cnt == CntLimit) ? r_wait_cnt : r_wait_cnt + CntWidth'(1);
   assign w_starved = (w_cnt_inc == CntLimit);

   always_comb begin
      rf_write_en   = 1'b0;
      rf_write_addr = '0;
      rf_write_data = '0;
      if (w_pipe_grant) begin
         rf_write_en   = (pipe_addr != '0);
         rf_write_addr = pipe_addr;
         rf_write_data = pipe_data;
      end else if (w_xfer) begin
         rf_write_en   = (mc_addr != '0);
         rf_write_addr = mc_addr;
         rf_write_data = mc_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_wait_cnt <= '0;
         r_stall    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_refused) begin
                  r_wait_cnt <= w_cnt_inc;
                  if (w_starved) begin
                     r_state <= StForce;
                     r_stall <= 1'b1;
                  end else begin
                     r_state <= StWait;
                  end
               end
            end
            StWait: begin
               if (w_xfer || !mc_valid) begin
                  r_state    <= StIdle;
                  r_wait_cnt <= '0;
               end else begin
                  r_wait_cnt <= w_cnt_inc;
                  if (w_starved) begin
                     r_state <= StForce;
                     r_stall <= 1'b1;
                  end
               end
            end
            StForce: begin
               // mc_ready is 1 here, so any valid result transfers this cycle.
               if (w_xfer || !mc_valid) begin
                  r_state    <= StIdle;
                  r_wait_cnt <= '0;
                  r_stall    <= 1'b0;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_wait_cnt <= '0;
               r_stall    <= 1'b0;
            end
         endcase
      end
   end

   // Clear before set so a same-address issue and completion leaves the bit pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_xfer) begin
         w_busy_nxt[mc_addr] = 1'b0;
      end
      if (mc_issue) begin
         w_busy_nxt[mc_issue_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign mc_ready  = w_mc_ready;
   assign stall_req = r_stall;
   assign busy_mask = r_busy;

   stall_matches_force: assert property (@(posedge clk) disable iff (!rst_n)
      r_stall == (r_state == StForce));
   x0_never_busy: assert property (@(posedge clk) disable iff (!rst_n) r_busy[0] == 1'b0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected register-file writes are queued as stimulus
// is driven and matched by a negedge monitor; scenario tasks check control outputs inline.
module tb_wb_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pipe_valid = 1'b0;
   logic [AW-1:0]   pipe_addr = '0;
   logic [DW-1:0]   pipe_data = '0;
   logic            mc_issue = 1'b0;
   logic [AW-1:0]   mc_issue_addr = '0;
   logic            mc_valid = 1'b0;
   logic [AW-1:0]   mc_addr = '0;
   logic [DW-1:0]   mc_data = '0;
   logic            mc_ready;
   logic            stall_req;
   logic            rf_write_en;
   logic [AW-1:0]   rf_write_addr;
   logic [DW-1:0]   rf_write_data;
   logic [2**AW-1:0] busy_mask;

   int  n_tests = 0;
   int  n_fail  = 0;
   wr_t exp_q[$];
   wr_t mon_exp;

   wb_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .STARVE_LIMIT  (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pipe_valid    (pipe_valid),
      .pipe_addr     (pipe_addr),
      .pipe_data     (pipe_data),
      .mc_issue      (mc_issue),
      .mc_issue_addr (mc_issue_addr),
      .mc_valid      (mc_valid),
      .mc_addr       (mc_addr),
      .mc_data       (mc_data),
      .mc_ready      (mc_ready),
      .stall_req     (stall_req),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .busy_mask     (busy_mask)
   );

   always #5 clk = ~clk;

   // Every enabled write must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rf_write_en !== 1'b0) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rf_unexpected_write: got en %b addr %0d data %h, required no write",
                     rf_write_en, rf_write_addr, rf_write_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rf_write_addr !== mon_exp.addr || rf_write_data !== mon_exp.data) begin
               n_fail++;
               $display("FAIL rf_write: got addr %0d data %h, required addr %0d data %h",
                        rf_write_addr, rf_write_data, mon_exp.addr, mon_exp.data);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (stall_req !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall: got %b, required 0", stall_req);
      end
      n_tests++;
      if (busy_mask !== '0) begin
         n_fail++; $display("FAIL reset_busy: got %h, required 0", busy_mask);
      end
      n_tests++;
      if (rf_write_en !== 1'b0 || rf_write_addr !== '0 || rf_write_data !== '0) begin
         n_fail++;
         $display("FAIL reset_rf_idle: got en %b addr %0d data %h, required 0/0/0",
                  rf_write_en, rf_write_addr, rf_write_data);
      end
      n_tests++;
      if (mc_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mc_ready: got %b, required 1", mc_ready);
      end
      // Arbitration stays combinational while reset is held.
      cyc();
      pipe_valid = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h55;
      push_wr(5'd3, 32'h55);
      @(negedge clk);
      n_tests++;
      if (mc_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_pipe_priority: got mc_ready %b, required 0", mc_ready);
      end
      cyc();
      pipe_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_pipe_only();
      cyc();
      pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hAA;
      push_wr(5'd5, 32'hAA);
      @(negedge clk);
      n_tests++;
      if (rf_write_en !== 1'b1 || stall_req !== 1'b0) begin
         n_fail++;
         $display("FAIL pipe_only: got en %b stall %b, required en 1 stall 0", rf_write_en,
                  stall_req);
      end
      cyc();
      pipe_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rf_write_en !== 1'b0 || rf_write_addr !== '0 || rf_write_data !== '0) begin
         n_fail++;
         $display("FAIL no_grant_zero: got en %b addr %0d data %h, required 0/0/0",
                  rf_write_en, rf_write_addr, rf_write_data);
      end
   endtask

   task automatic test_mc_issue();
      cyc();
      mc_issue = 1'b1; mc_issue_addr = 5'd7;
      @(negedge clk);
      n_tests++;
      if (busy_mask[7] !== 1'b0) begin
         n_fail++; $display("FAIL busy_set_early: got %b, required 0", busy_mask[7]);
      end
      cyc();
      mc_issue = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_mask[7] !== 1'b1) begin
         n_fail++; $display("FAIL busy_set: got %b, required 1", busy_mask[7]);
      end
      cyc();
      mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h1234;
      push_wr(5'd7, 32'h1234);
      @(negedge clk);
      n_tests++;
      if (mc_ready !== 1'b1 || busy_mask[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL mc_xfer: got ready %b busy7 %b, required 1/1", mc_ready, busy_mask[7]);
      end
      cyc();
      mc_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_mask[7] !== 1'b0) begin
         n_fail++; $display("FAIL busy_clear: got %b, required 0", busy_mask[7]);
      end
   endtask

   task automatic test_starve();
      cyc();
      pipe_valid = 1'b1; pipe_addr = 5'd3;
      mc_valid = 1'b1; mc_addr = 5'd10; mc_data = 32'hBEEF;
      for (int k = 0; k < 4; k++) begin
         pipe_data = 32'h100 + 32'(k);
         push_wr(5'd3, 32'h100 + 32'(k));
         @(negedge clk);
         n_tests++;
         if (mc_ready !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_refuse%0d: got ready %b stall %b, required 0/0", k, mc_ready,
                     stall_req);
         end
         cyc();
      end
      pipe_data = 32'h200;
      push_wr(5'd10, 32'hBEEF);
      @(negedge clk);
      n_tests++;
      if (stall_req !== 1'b1 || mc_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_force: got stall %b ready %b, required 1/1", stall_req, mc_ready);
      end
      cyc();
      mc_valid = 1'b0;
      push_wr(5'd3, 32'h200);
      @(negedge clk);
      n_tests++;
      if (stall_req !== 1'b0) begin
         n_fail++; $display("FAIL starve_release: got stall %b, required 0", stall_req);
      end
      cyc();
      pipe_valid = 1'b0;
   endtask

   task automatic test_same_addr();
      cyc();
      mc_issue = 1'b1; mc_issue_addr = 5'd9;
      cyc();
      mc_issue = 1'b0;
      cyc();
      mc_issue = 1'b1; mc_issue_addr = 5'd9;
      mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99;
      push_wr(5'd9, 32'h99);
      cyc();
      mc_issue = 1'b0; mc_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_mask[9] !== 1'b1) begin
         n_fail++; $display("FAIL same_addr_keep: got %b, required 1", busy_mask[9]);
      end
      cyc();
      mc_valid = 1'b1; mc_data = 32'h9A;
      push_wr(5'd9, 32'h9A);
      cyc();
      mc_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_mask[9] !== 1'b0) begin
         n_fail++; $display("FAIL same_addr_clear: got %b, required 0", busy_mask[9]);
      end
   endtask

   task automatic test_x0();
      cyc();
      pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h77;
      @(negedge clk);
      n_tests++;
      if (rf_write_en !== 1'b0) begin
         n_fail++; $display("FAIL pipe_x0: got en %b, required 0", rf_write_en);
      end
      cyc();
      pipe_valid = 1'b0;
      mc_issue = 1'b1; mc_issue_addr = 5'd0;
      mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h66;
      @(negedge clk);
      n_tests++;
      if (rf_write_en !== 1'b0 || mc_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mc_x0: got en %b ready %b, required 0/1", rf_write_en, mc_ready);
      end
      cyc();
      mc_issue = 1'b0; mc_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_mask !== '0) begin
         n_fail++; $display("FAIL busy_x0: got %h, required 0", busy_mask);
      end
   endtask

   task automatic test_reset_force();
      cyc();
      mc_issue = 1'b1; mc_issue_addr = 5'd12;
      cyc();
      mc_issue = 1'b0;
      pipe_valid = 1'b1; pipe_addr = 5'd3;
      mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'hC0DE;
      for (int k = 0; k < 4; k++) begin
         pipe_data = 32'h300 + 32'(k);
         push_wr(5'd3, 32'h300 + 32'(k));
         cyc();
      end
      #1;
      n_tests++;
      if (stall_req !== 1'b1 || busy_mask[12] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_force: got stall %b busy12 %b, required 1/1", stall_req,
                  busy_mask[12]);
      end
      rst_n = 1'b0;
      push_wr(5'd3, 32'h303);
      #1;
      n_tests++;
      if (stall_req !== 1'b0 || busy_mask !== '0) begin
         n_fail++;
         $display("FAIL reset_in_force: got stall %b busy %h, required 0/0", stall_req,
                  busy_mask);
      end
      @(negedge clk);
      n_tests++;
      if (mc_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle_priority: got ready %b, required 0", mc_ready);
      end
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pipe_data = 32'h400 + 32'(k);
         push_wr(5'd3, 32'h400 + 32'(k));
         @(negedge clk);
         n_tests++;
         if (stall_req !== 1'b0) begin
            n_fail++; $display("FAIL history_cleared%0d: got stall %b, required 0", k, stall_req);
         end
         cyc();
      end
      pipe_valid = 1'b0;
      push_wr(5'd12, 32'hC0DE);
      @(negedge clk);
      n_tests++;
      if (mc_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_xfer: got ready %b, required 1", mc_ready);
      end
      cyc();
      mc_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_mc_issue();
      test_starve();
      test_same_addr();
      test_x0();
      test_reset_force();
      cyc();
      cyc();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_writes: got %0d unconsumed, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
